// File: rtl/raybox_input_ctrl.sv
// Player-input front end for raybox: synchronise and debounce the four
// active-low buttons, resolve combinations into modes, latch commands per frame.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_NORMAL  | buttons map to moves (L=K3, R=K2, F=K4, B=K1)
// ST_DEBUG1  | entered by K2+K3; K4 -> debugA, K1 -> debugB
// ST_DEBUG2  | entered by K1+K4; K2 -> debugC, K3 -> debugD
// ST_RELEASE | combo broken; wait for every button up before NORMAL
module raybox_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] btn_n,
  input  logic       vsync,
  output logic [3:0] btn_state,
  output logic [1:0] mode,
  output logic       moveL,
  output logic       moveR,
  output logic       moveF,
  output logic       moveB,
  output logic       debugA,
  output logic       debugB,
  output logic       debugC,
  output logic       debugD,
  output logic       frame_tick
);

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'd0,
    ST_DEBUG1  = 2'd1,
    ST_DEBUG2  = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]            sync1_q, sync2_q;
  logic [3:0]            stable_q, stable_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  state_t                state_q, state_d;
  logic                  vsync_q;
  logic                  rise;
  logic [7:0]            cmd_q, cmd_d;
  logic                  tick_q;
  logic [3:0]            p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  // A mismatch must persist DEBOUNCE_CYCLES consecutive cycles; any return
  // to the stable level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = sync2_q[i];
        cnt_d[i]    = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= 4'hF;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign p = ~stable_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = 8'h00;
    unique case (state_q)
      ST_NORMAL: begin
        cmd_d = {p[2], p[1], p[3], p[0], 4'b0000};
        // K2+K3 wins over K1+K4 when all four are held.
        if (p[1] && p[2]) begin
          state_d = ST_DEBUG1;
        end else if (p[0] && p[3]) begin
          state_d = ST_DEBUG2;
        end
      end
      ST_DEBUG1: begin
        cmd_d = {4'b0000, p[3], p[0], 2'b00};
        if (!p[1] || !p[2]) begin
          state_d = ST_RELEASE;
        end
      end
      ST_DEBUG2: begin
        cmd_d = {4'b0000, 2'b00, p[1], p[2]};
        if (!p[0] || !p[3]) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (p == 4'b0000) begin
          state_d = ST_NORMAL;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  assign rise = vsync & ~vsync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q <= 1'b0;
      cmd_q   <= 8'h00;
      tick_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      tick_q  <= rise;
      if (rise) begin
        cmd_q <= cmd_d;
      end
    end
  end

  assign btn_state  = p;
  assign mode       = state_q;
  assign moveL      = cmd_q[7];
  assign moveR      = cmd_q[6];
  assign moveF      = cmd_q[5];
  assign moveB      = cmd_q[4];
  assign debugA     = cmd_q[3];
  assign debugB     = cmd_q[2];
  assign debugC     = cmd_q[1];
  assign debugD     = cmd_q[0];
  assign frame_tick = tick_q;

endmodule
